dm_write_buffer: RTL
====================

// Module: dm_write_buffer
// PURPOSE
//  Store buffer between the datapath's memory stage and the data memory. Queues
//  stores in a FIFO and retires them to the data memory in idle cycles, so loads
//  get the single shared memory address port first. Loads forward the youngest
//  matching buffered store. Outputs stall when the buffer cannot accept a store.
// PARAMETERS
//  WIDTH      21  data word width; matches data memory word
//  ADDR_BITS  6   word address width; matches data memory depth 2**ADDR_BITS
//  DEPTH      4   buffer entries; power of two, >=2
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous, active-high reset
//  cpu_addr   in   ADDR_BITS  load/store word address
//  cpu_wdata  in   WIDTH      store data
//  cpu_we     in   1          store request
//  cpu_re     in   1          load request
//  cpu_rdata  out  WIDTH      load data (combinational)
//  stall      out  1          hold PC/pipeline this cycle; request not taken
//  wb_empty   out  1          no buffered stores (used before halt/dump)
//  dm_addr    out  ADDR_BITS  to data memory Address
//  dm_wdata   out  WIDTH      to data memory DataIn
//  dm_we      out  1          to data memory MemWrite
//  dm_rdata   in   WIDTH      from data memory DataOut
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. Clock is clk, reset is rst.
//  - State: DEPTH entries {addr,data}, head/tail ptrs (clog2(DEPTH) bits, wrap
//    mod DEPTH), count (clog2(DEPTH)+1 bits, range 0..DEPTH).
//  - Reset: count=0, head=tail=0. Outputs after reset: dm_we=0, stall=0,
//    wb_empty=1. Reset mid-operation discards buffered stores; none are written.
//  - full = (count==DEPTH); empty = (count==0); wb_empty = empty.
//  - Store: cpu_we && !full -> entry written at tail on edge; tail++, count++.
//    cpu_we && full -> stall=1, nothing enqueued.
//  - cpu_we && cpu_re together: illegal; treated as store only, cpu_re ignored.
//  - Drain: !empty && !cpu_re -> dm_we=1, dm_addr/dm_wdata = head entry;
//    head++, count-- on edge. Otherwise dm_we=0, dm_addr=cpu_addr.
//  - Load has priority for the memory port: cpu_re -> dm_addr=cpu_addr, no drain.
//  - Enqueue and drain in the same cycle: count unchanged, both ptrs advance.
//    A store arriving while full stalls even if a drain happens that cycle; it
//    is accepted next cycle.
//  - Store latency: enqueued at edge k, earliest memory write at edge k+1.
//  - Load with no buffer match: cpu_rdata = dm_rdata, same cycle.
//  - Match = valid entry with addr==cpu_addr; youngest (nearest tail) wins.
//  - stall = (cpu_we && full) || (load-stall condition below).
//  - Loads never modify buffer state.
// CONFIGURATION
//  WBUF_FORWARD_EN defined: load match -> cpu_rdata = youngest matching data,
//    no stall.
//  WBUF_FORWARD_EN undefined: load match -> stall=1, cpu_rdata undefined. The
//    load does not block draining for that cycle (port released to drain).
//    Load resumes when no match remains.
// TESTING
//  1 rst=1 2 cycles, then idle -> dm_we=0, stall=0, wb_empty=1, count 0.
//  2 store A=5 D=0x1ABCD, idle 1 cycle -> dm_we=1 addr 5 data 0x1ABCD; then
//    wb_empty=1; load addr 5 -> cpu_rdata=0x1ABCD via memory.
//  3 Continuous loads plus 4 stores to 1..4, then a 5th store -> stall=1 on 5th.
//    Drop loads -> one drain per cycle in order 1,2,3,4; 5th store accepted.
//  4 stores addr 9 = 0x00011, then 0x00022; immediate load 9 -> with
//    WBUF_FORWARD_EN: 0x00022, stall=0. Without it: stall until both drained,
//    then 0x00022.
//  5 Full buffer, rst=1 one cycle -> wb_empty=1, no dm_we, memory unchanged.
//  6 10 store/drain cycles over DEPTH=4 -> pointer wrap; every drain matches its
//    store in order, count never exceeds 4.

Source files
------------

// File: rtl/dm_write_buffer.sv
// -----------------------------------------------------------------------------
// dm_write_buffer
//   Store buffer between the memory stage and the data memory. Stores are queued
//   in a small FIFO and written to memory in cycles where no load needs the single
//   shared address port. Loads see the youngest buffered store to the same
//   address, either by forwarding its data or by stalling until it has drained.
//
// Configuration macro:
//   WBUF_FORWARD_EN  defined   : a load that hits the buffer gets the youngest
//                                matching data, no stall.
//                    undefined : a load that hits the buffer stalls. The memory
//                                port is released to the drain for that cycle,
//                                and the load retries until no match remains.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (discards buffered stores)
//   cpu_addr   load/store word address
//   cpu_wdata  store data
//   cpu_we     store request
//   cpu_re     load request (ignored for loads when cpu_we is also high)
//   cpu_rdata  load data, combinational
//   stall      request not taken this cycle; hold the pipeline
//   wb_empty   no buffered stores
//   dm_addr    data memory address
//   dm_wdata   data memory write data
//   dm_we      data memory write enable
//   dm_rdata   data memory read data
// -----------------------------------------------------------------------------
module dm_write_buffer #(
  parameter int WIDTH     = 21,
  parameter int ADDR_BITS = 6,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [WIDTH-1:0]     cpu_wdata,
  input  logic                 cpu_we,
  input  logic                 cpu_re,
  output logic [WIDTH-1:0]     cpu_rdata,
  output logic                 stall,
  output logic                 wb_empty,
  output logic [ADDR_BITS-1:0] dm_addr,
  output logic [WIDTH-1:0]     dm_wdata,
  output logic                 dm_we,
  input  logic [WIDTH-1:0]     dm_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_BITS-1:0] addr_mem_r [DEPTH];
  logic [WIDTH-1:0]     data_mem_r [DEPTH];
  logic [PTR_W-1:0]     head_r;
  logic [PTR_W-1:0]     tail_r;
  logic [CNT_W-1:0]     count_r;

  logic                 full_s;
  logic                 empty_s;
  logic                 load_s;
  logic                 match_s;
  logic                 hit_s;
  logic [PTR_W-1:0]     slot_s;
  logic                 load_stall_s;
  logic                 push_s;
  logic                 drain_s;
`ifdef WBUF_FORWARD_EN
  logic [WIDTH-1:0]     match_data_s;
`endif

  // Associative search, oldest to youngest, so the last hit is the youngest.
  always_comb begin
    match_s = 1'b0;
    hit_s   = 1'b0;
    slot_s  = head_r;
`ifdef WBUF_FORWARD_EN
    match_data_s = {WIDTH{1'b0}};
`endif
    for (int i = 0; i < DEPTH; i++) begin
      slot_s  = head_r + PTR_W'(i);
      hit_s   = (CNT_W'(i) < count_r) && (addr_mem_r[slot_s] == cpu_addr);
      match_s = match_s | hit_s;
`ifdef WBUF_FORWARD_EN
      match_data_s = hit_s ? data_mem_r[slot_s] : match_data_s;
`endif
    end
  end

  // Occupancy flags and the accept/drain decision for this cycle.
  always_comb begin
    full_s  = (count_r == CNT_W'(DEPTH));
    empty_s = (count_r == {CNT_W{1'b0}});
    // A simultaneous store and load is treated as a store only.
    load_s  = cpu_re && !cpu_we;
    push_s  = !rst && cpu_we && !full_s;
`ifdef WBUF_FORWARD_EN
    load_stall_s = 1'b0;
    drain_s      = !rst && !empty_s && !cpu_re;
`else
    load_stall_s = load_s && match_s;
    // A load stalled on a match gives its port slot to the drain so the
    // matching entries can leave the buffer.
    drain_s      = !rst && !empty_s && (!cpu_re || load_stall_s);
`endif
  end

  // Memory port, load data and pipeline handshake.
  always_comb begin
    dm_we    = drain_s;
    dm_addr  = drain_s ? addr_mem_r[head_r] : cpu_addr;
    dm_wdata = data_mem_r[head_r];
    stall    = (cpu_we && full_s) || load_stall_s;
    wb_empty = empty_s;
`ifdef WBUF_FORWARD_EN
    cpu_rdata = (load_s && match_s) ? match_data_s : dm_rdata;
`else
    cpu_rdata = dm_rdata;
`endif
  end

  // Entry storage; validity comes from count, so contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_r[tail_r] <= cpu_addr;
      data_mem_r[tail_r] <= cpu_wdata;
    end else begin
      addr_mem_r[tail_r] <= addr_mem_r[tail_r];
      data_mem_r[tail_r] <= data_mem_r[tail_r];
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end else begin
        tail_r <= tail_r;
      end
      if (drain_s) begin
        head_r <= head_r + PTR_W'(1);
      end else begin
        head_r <= head_r;
      end
      case ({push_s, drain_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
